// File: rtl/div_reservation_station_pkg.sv
// Shared types for the divide reservation station: operand/entry records and
// the CDB snoop used by both dispatch bypass and wakeup.
package div_rs_pkg;

  localparam int TAG_WIDTH  = 6;
  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic                  ready;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] value;
  } rs_src_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] dest_tag;
    rs_src_t              src1;
    rs_src_t              src2;
  } rs_entry_t;

  // A waiting source captures the broadcast value when its producer tag matches.
  function automatic rs_src_t snoop_cdb(rs_src_t src, logic cdb_valid,
                                        logic [TAG_WIDTH-1:0] cdb_tag,
                                        logic [DATA_WIDTH-1:0] cdb_data);
    rs_src_t res;
    res = src;
    if (!src.ready && cdb_valid && (cdb_tag == src.tag)) begin
      res.ready = 1'b1;
      res.value = cdb_data;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_reservation_station_if.sv
// Dispatch, CDB, divider-issue and occupancy signals of the divide reservation station.
interface div_rs_if #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = div_rs_pkg::DATA_WIDTH,
  parameter int TAG_WIDTH  = div_rs_pkg::TAG_WIDTH
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  dispatch_valid;
  logic [TAG_WIDTH-1:0]  dispatch_dest_tag;
  logic                  dispatch_src1_ready;
  logic                  dispatch_src2_ready;
  logic [DATA_WIDTH-1:0] dispatch_src1_value;
  logic [DATA_WIDTH-1:0] dispatch_src2_value;
  logic [TAG_WIDTH-1:0]  dispatch_src1_tag;
  logic [TAG_WIDTH-1:0]  dispatch_src2_tag;
  logic                  cdb_valid;
  logic [TAG_WIDTH-1:0]  cdb_tag;
  logic [DATA_WIDTH-1:0] cdb_data;
  logic                  div_busy;
  logic                  issue_enable;
  logic [DATA_WIDTH-1:0] issue_op1;
  logic [DATA_WIDTH-1:0] issue_op2;
  logic [TAG_WIDTH-1:0]  issue_tag;
  logic                  full;
  logic [CW-1:0]         count;

  modport master (
    output flush, dispatch_valid, dispatch_dest_tag,
           dispatch_src1_ready, dispatch_src2_ready,
           dispatch_src1_value, dispatch_src2_value,
           dispatch_src1_tag, dispatch_src2_tag,
           cdb_valid, cdb_tag, cdb_data, div_busy,
    input  issue_enable, issue_op1, issue_op2, issue_tag, full, count
  );

  modport slave (
    input  flush, dispatch_valid, dispatch_dest_tag,
           dispatch_src1_ready, dispatch_src2_ready,
           dispatch_src1_value, dispatch_src2_value,
           dispatch_src1_tag, dispatch_src2_tag,
           cdb_valid, cdb_tag, cdb_data, div_busy,
    output issue_enable, issue_op1, issue_op2, issue_tag, full, count
  );
endinterface

// File: rtl/div_reservation_station_priority_encoder.sv
// Lowest-set-bit encoder; used for free-slot allocation and ready-entry selection.
module rs_priority_encoder #(
  parameter int WIDTH = 4,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [IW-1:0]    idx,
  output logic             found
);

  // Scanning downward lets the lowest set bit win.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_reservation_station.sv
// Holds pending divides until both operands arrive, snooping the CDB, and issues
// the lowest-index ready entry to the divider whenever it is not busy.
module div_reservation_station
  import div_rs_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = div_rs_pkg::DATA_WIDTH,
  parameter int TAG_WIDTH  = div_rs_pkg::TAG_WIDTH
) (
  input logic   clk,
  input logic   reset,
  div_rs_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  rs_entry_t             entries [DEPTH];
  logic [DEPTH-1:0]      free_vec;
  logic [DEPTH-1:0]      ready_vec;
  logic [IW-1:0]         free_idx;
  logic [IW-1:0]         sel_idx;
  logic                  free_found;
  logic                  sel_found;
  logic                  full_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_next;
  logic                  do_issue;
  logic                  do_alloc;
  rs_src_t               src1_in;
  rs_src_t               src2_in;
  rs_entry_t             new_entry;
  logic [DATA_WIDTH-1:0] sel_op1;
  logic [DATA_WIDTH-1:0] sel_op2;
  logic [TAG_WIDTH-1:0]  sel_tag;

  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i]  = !entries[i].valid;
      ready_vec[i] = entries[i].valid && entries[i].src1.ready && entries[i].src2.ready;
    end
  end

  rs_priority_encoder #(.WIDTH(DEPTH), .IW(IW)) u_free_pe (
    .req   (free_vec),
    .idx   (free_idx),
    .found (free_found)
  );

  rs_priority_encoder #(.WIDTH(DEPTH), .IW(IW)) u_sel_pe (
    .req   (ready_vec),
    .idx   (sel_idx),
    .found (sel_found)
  );

  // Allocation uses the registered full flag, so a slot released this cycle
  // only becomes allocatable after the edge.
  assign do_issue   = sel_found && !bus.div_busy && !bus.flush;
  assign do_alloc   = bus.dispatch_valid && !full_q && free_found && !bus.flush;
  assign count_next = count_q + CW'(do_alloc) - CW'(do_issue);

  always_comb begin
    src1_in        = '0;
    src2_in        = '0;
    src1_in.ready  = bus.dispatch_src1_ready;
    src1_in.tag    = bus.dispatch_src1_tag;
    src1_in.value  = bus.dispatch_src1_value;
    src2_in.ready  = bus.dispatch_src2_ready;
    src2_in.tag    = bus.dispatch_src2_tag;
    src2_in.value  = bus.dispatch_src2_value;
    new_entry          = '0;
    new_entry.valid    = 1'b1;
    new_entry.dest_tag = bus.dispatch_dest_tag;
    new_entry.src1     = snoop_cdb(src1_in, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    new_entry.src2     = snoop_cdb(src2_in, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  end

  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    sel_tag = '0;
    if (do_issue) begin
      sel_op1 = entries[sel_idx].src1.value;
      sel_op2 = entries[sel_idx].src2.value;
      sel_tag = entries[sel_idx].dest_tag;
    end
  end

  assign bus.issue_enable = do_issue;
  assign bus.issue_op1    = sel_op1;
  assign bus.issue_op2    = sel_op2;
  assign bus.issue_tag    = sel_tag;
  assign bus.full         = full_q;
  assign bus.count        = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries[i].valid) begin
          entries[i].src1 <= snoop_cdb(entries[i].src1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
          entries[i].src2 <= snoop_cdb(entries[i].src2, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        end
      end
      if (do_issue) entries[sel_idx].valid <= 1'b0;
      if (do_alloc) entries[free_idx] <= new_entry;
      count_q <= count_next;
      full_q  <= (count_next == CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_div_reservation_station.sv
// Directed and random stimulus for the divide reservation station, checked
// against an array-based reference model plus a 7-cycle divider busy model.
module tb_div_reservation_station;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int TW    = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;

  div_rs_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  div_reservation_station #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  bit          e_valid [DEPTH];
  bit          e_r1    [DEPTH];
  bit          e_r2    [DEPTH];
  logic [TW-1:0] e_dest [DEPTH];
  logic [TW-1:0] e_t1   [DEPTH];
  logic [TW-1:0] e_t2   [DEPTH];
  logic [DW-1:0] e_v1   [DEPTH];
  logic [DW-1:0] e_v2   [DEPTH];
  int          busy_cnt;

  logic          obs_en;
  logic [DW-1:0] obs_op1;
  logic [DW-1:0] obs_op2;
  logic [TW-1:0] obs_tag;
  logic          obs_full;
  logic [2:0]    obs_count;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic set_disp(input bit v, input logic [TW-1:0] d,
                          input bit r1, input logic [DW-1:0] v1, input logic [TW-1:0] t1,
                          input bit r2, input logic [DW-1:0] v2, input logic [TW-1:0] t2);
    bus.dispatch_valid      = v;
    bus.dispatch_dest_tag   = d;
    bus.dispatch_src1_ready = r1;
    bus.dispatch_src1_value = v1;
    bus.dispatch_src1_tag   = t1;
    bus.dispatch_src2_ready = r2;
    bus.dispatch_src2_value = v2;
    bus.dispatch_src2_tag   = t2;
  endtask

  task automatic set_cdb(input bit v, input logic [TW-1:0] t, input logic [DW-1:0] d);
    bus.cdb_valid = v;
    bus.cdb_tag   = t;
    bus.cdb_data  = d;
  endtask

  task automatic idle();
    set_disp(1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
    set_cdb(1'b0, '0, '0);
    bus.flush = 1'b0;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) e_valid[i] = 1'b0;
  endfunction

  // Called just after a rising edge with inputs already set; checks mid-cycle,
  // then advances the model across the next edge.
  task automatic step();
    int cand, cnt, free;
    bit exp_en;
    logic [DW-1:0] x1, x2;
    logic [TW-1:0] xt;
    bus.div_busy = (busy_cnt != 0);
    cand = -1;
    cnt  = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (e_valid[i]) cnt++;
      if (cand < 0 && e_valid[i] && e_r1[i] && e_r2[i]) cand = i;
    end
    exp_en = (cand >= 0) && !bus.div_busy && !bus.flush;
    x1 = '0; x2 = '0; xt = '0;
    if (exp_en) begin
      x1 = e_v1[cand]; x2 = e_v2[cand]; xt = e_dest[cand];
    end
    #3;
    obs_en    = bus.issue_enable;
    obs_op1   = bus.issue_op1;
    obs_op2   = bus.issue_op2;
    obs_tag   = bus.issue_tag;
    obs_full  = bus.full;
    obs_count = bus.count;
    check("issue_enable", 64'(obs_en), 64'(exp_en));
    check("issue_op1", 64'(obs_op1), 64'(x1));
    check("issue_op2", 64'(obs_op2), 64'(x2));
    check("issue_tag", 64'(obs_tag), 64'(xt));
    check("count", 64'(obs_count), 64'(cnt));
    check("full", 64'(obs_full), 64'(cnt == DEPTH));
    @(posedge clk);
    if (exp_en) busy_cnt = 7;
    else if (busy_cnt > 0) busy_cnt--;
    if (bus.flush) begin
      model_clear();
    end else begin
      free = -1;
      for (int i = 0; i < DEPTH; i++) if (!e_valid[i] && free < 0) free = i;
      for (int i = 0; i < DEPTH; i++) begin
        if (e_valid[i] && bus.cdb_valid) begin
          if (!e_r1[i] && bus.cdb_tag == e_t1[i]) begin e_r1[i] = 1'b1; e_v1[i] = bus.cdb_data; end
          if (!e_r2[i] && bus.cdb_tag == e_t2[i]) begin e_r2[i] = 1'b1; e_v2[i] = bus.cdb_data; end
        end
      end
      if (exp_en) e_valid[cand] = 1'b0;
      if (bus.dispatch_valid && cnt < DEPTH) begin
        e_valid[free] = 1'b1;
        e_dest[free]  = bus.dispatch_dest_tag;
        e_t1[free]    = bus.dispatch_src1_tag;
        e_t2[free]    = bus.dispatch_src2_tag;
        e_r1[free]    = bus.dispatch_src1_ready || (bus.cdb_valid && bus.cdb_tag == bus.dispatch_src1_tag);
        e_r2[free]    = bus.dispatch_src2_ready || (bus.cdb_valid && bus.cdb_tag == bus.dispatch_src2_tag);
        e_v1[free]    = bus.dispatch_src1_ready ? bus.dispatch_src1_value : bus.cdb_data;
        e_v2[free]    = bus.dispatch_src2_ready ? bus.dispatch_src2_value : bus.cdb_data;
      end
    end
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (8) step();
  endtask

  task automatic run_until_issue(input int budget, output bit found, output int cycles);
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < budget) begin
      step();
      cycles++;
      if (obs_en) found = 1'b1;
    end
  endtask

  // Reset lands mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset_mid();
    idle();
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_enable", 64'(bus.issue_enable), 64'd0);
    check("rst_async_op1", 64'(bus.issue_op1), 64'd0);
    check("rst_async_op2", 64'(bus.issue_op2), 64'd0);
    check("rst_async_tag", 64'(bus.issue_tag), 64'd0);
    check("rst_async_count", 64'(bus.count), 64'd0);
    check("rst_async_full", 64'(bus.full), 64'd0);
    model_clear();
    busy_cnt     = 0;
    bus.div_busy = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bit found;
    int cycles;
    idle();
    bus.div_busy = 1'b0;
    busy_cnt = 0;
    model_clear();
    @(posedge clk);
    #1;
    check("reset_enable", 64'(bus.issue_enable), 64'd0);
    check("reset_op1", 64'(bus.issue_op1), 64'd0);
    check("reset_count", 64'(bus.count), 64'd0);
    check("reset_full", 64'(bus.full), 64'd0);
    reset = 1'b0;

    // ready dispatch
    set_disp(1'b1, 6'd5, 1'b1, 32'd100, '0, 1'b1, 32'd7, '0);
    step();
    check("ready_no_early_issue", 64'(obs_en), 64'd0);
    idle();
    step();
    check("ready_issue_en", 64'(obs_en), 64'd1);
    check("ready_issue_op1", 64'(obs_op1), 64'd100);
    check("ready_issue_op2", 64'(obs_op2), 64'd7);
    check("ready_issue_tag", 64'(obs_tag), 64'd5);
    step();
    check("ready_count_back_0", 64'(obs_count), 64'd0);
    drain();

    // wakeup two cycles after dispatch
    set_disp(1'b1, 6'd3, 1'b1, 32'd20, '0, 1'b0, '0, 6'd9);
    step();
    idle();
    step();
    set_cdb(1'b1, 6'd9, 32'd4);
    step();
    check("wake_no_same_cycle", 64'(obs_en), 64'd0);
    idle();
    step();
    check("wake_issue_en", 64'(obs_en), 64'd1);
    check("wake_issue_op2", 64'(obs_op2), 64'd4);
    check("wake_issue_tag", 64'(obs_tag), 64'd3);
    drain();

    // dispatch bypass
    set_disp(1'b1, 6'd1, 1'b0, '0, 6'd12, 1'b1, 32'd3, '0);
    set_cdb(1'b1, 6'd12, 32'h55);
    step();
    idle();
    step();
    check("bypass_issue_en", 64'(obs_en), 64'd1);
    check("bypass_issue_op1", 64'(obs_op1), 64'h55);
    drain();

    // double wakeup on one broadcast
    set_disp(1'b1, 6'd2, 1'b0, '0, 6'd12, 1'b0, '0, 6'd12);
    step();
    idle();
    set_cdb(1'b1, 6'd12, 32'h77);
    step();
    idle();
    step();
    check("double_issue_en", 64'(obs_en), 64'd1);
    check("double_op1", 64'(obs_op1), 64'h77);
    check("double_op2", 64'(obs_op2), 64'h77);
    drain();

    // busy gating: tag 11 lands in freed slot 0 and must go before tag 10
    set_disp(1'b1, 6'd9, 1'b1, 32'd50, '0, 1'b1, 32'd5, '0);
    step();
    set_disp(1'b1, 6'd10, 1'b1, 32'd60, '0, 1'b1, 32'd6, '0);
    step();
    check("gate_first_issue", 64'(obs_tag), 64'd9);
    set_disp(1'b1, 6'd11, 1'b1, 32'd70, '0, 1'b1, 32'd7, '0);
    step();
    idle();
    run_until_issue(20, found, cycles);
    check("gate_second_found", 64'(found), 64'd1);
    check("gate_lowest_index", 64'(obs_tag), 64'd11);
    run_until_issue(20, found, cycles);
    check("gate_third_found", 64'(found), 64'd1);
    check("gate_third_tag", 64'(obs_tag), 64'd10);
    check("gate_busy_gap", 64'(cycles), 64'd8);
    drain();

    // full and dropped dispatch
    for (int k = 0; k < 4; k++) begin
      set_disp(1'b1, TW'(40 + k), 1'b0, '0, TW'(40 + k), 1'b1, DW'(k + 1), '0);
      step();
    end
    set_disp(1'b1, 6'd50, 1'b1, 32'd1, '0, 1'b1, 32'd1, '0);
    step();
    check("full_flag", 64'(obs_full), 64'd1);
    check("full_count", 64'(obs_count), 64'd4);
    idle();
    step();
    check("full_drop_count", 64'(obs_count), 64'd4);
    set_cdb(1'b1, 6'd40, 32'h1234);
    step();
    idle();
    step();
    check("full_release_issue", 64'(obs_en), 64'd1);
    check("full_release_tag", 64'(obs_tag), 64'd40);
    set_disp(1'b1, 6'd51, 1'b1, 32'd8, '0, 1'b1, 32'd2, '0);
    step();
    check("full_after_release", 64'(obs_full), 64'd0);
    idle();
    step();
    check("full_realloc_count", 64'(obs_count), 64'd4);

    // reset while entries wait
    do_reset_mid();

    // flush with a ready candidate
    for (int k = 0; k < 3; k++) begin
      set_disp(1'b1, TW'(20 + k), 1'b0, '0, 6'd33, 1'b1, 32'd9, '0);
      step();
    end
    idle();
    set_cdb(1'b1, 6'd33, 32'd90);
    step();
    idle();
    bus.flush = 1'b1;
    step();
    check("flush_no_issue", 64'(obs_en), 64'd0);
    check("flush_count_before", 64'(obs_count), 64'd3);
    bus.flush = 1'b0;
    step();
    check("flush_count_after", 64'(obs_count), 64'd0);

    // random traffic
    for (int k = 0; k < 800; k++) begin
      set_disp(1'($urandom_range(0, 1)), TW'($urandom_range(0, 63)),
               ($urandom_range(0, 2) == 0), DW'($urandom), TW'($urandom_range(0, 7)),
               ($urandom_range(0, 2) == 0), DW'($urandom), TW'($urandom_range(0, 7)));
      set_cdb(($urandom_range(0, 2) == 0), TW'($urandom_range(0, 7)), DW'($urandom));
      bus.flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) do_reset_mid();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/div_reservation_station.md
# div_reservation_station

Reservation station that holds pending integer-divide operations until both source operands are available. It monitors the common data bus (CDB) for results that other units are producing, then issues one ready operation at a time to the downstream divider functional unit. It sits between the dispatch stage and the divider, and it is paced by the divider's `busy` output.

## Interface

Parameters:
- `DEPTH`, 4: number of entries (2..8).
- `DATA_WIDTH`, 32: operand width.
- `TAG_WIDTH`, 6: ROB/producer tag width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of all entries (branch mispredict).
- `dispatch_valid`  in  1  write a new operation this cycle.
- `dispatch_dest_tag`  in  TAG_WIDTH  destination tag of the operation.
- `dispatch_src1_ready`, `dispatch_src2_ready`  in  1  the source value is already valid.
- `dispatch_src1_value`, `dispatch_src2_value`  in  DATA_WIDTH  source value, used when ready.
- `dispatch_src1_tag`, `dispatch_src2_tag`  in  TAG_WIDTH  producer tag, used when not ready.
- `cdb_valid`  in  1  a broadcast is present on the CDB.
- `cdb_tag`  in  TAG_WIDTH  tag of the broadcast result.
- `cdb_data`  in  DATA_WIDTH  broadcast result value.
- `div_busy`  in  1  busy output of the divider.
- `issue_enable`  out  1  enable pulse to the divider.
- `issue_op1`, `issue_op2`  out  DATA_WIDTH  dividend and divisor.
- `issue_tag`  out  TAG_WIDTH  tag forwarded to the divider.
- `full`  out  1  all entries are valid.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.

## Operation

- Each entry holds: `valid`, `dest_tag`, and per source a `ready` bit, `tag` and `value`.
- **Allocation:** when `dispatch_valid` is high and `full` is low, write the lowest-index free entry. `dispatch_valid` while `full` is high is an upstream error; the station drops it and state is unchanged.
- **Dispatch bypass:** if a source is not ready at dispatch and `cdb_valid && cdb_tag == srcN_tag` in the same cycle, the entry stores `cdb_data` with `ready`=1.
- **Wakeup:** every cycle, each valid entry with `ready`=0 and a matching `cdb_tag` captures `cdb_data` and sets `ready`=1. Both sources of one entry may wake on the same broadcast.
- **Select:** the candidate is the lowest-index entry with `valid` set and both `ready` bits set (registered state only).
- **Issue:** `issue_enable` = candidate exists && !`div_busy` && !`flush`. The issue outputs present the candidate's values combinationally. When they are not issuing, the outputs are driven to 0.
- **Release:** the issued entry clears `valid` at the issuing clock edge. A released slot is not reallocated in the same cycle, because `full` and free-slot search use pre-edge state.
- **Flush:** clears every `valid` bit, suppresses `issue_enable`, and ignores a simultaneous dispatch. Flush has priority over dispatch, wakeup and issue.
- No arithmetic is performed here. Divide-by-zero is passed through to the divider unchanged.

## Timing

- Reset (asynchronous): all entries invalid, `count`=0, `full`=0, `issue_enable`=0, issue outputs 0.
- Dispatch with both sources ready at cycle t: earliest issue is cycle t+1.
- CDB wakeup at cycle t: earliest issue is cycle t+1. There is no same-cycle wakeup-to-issue.
- Divider handshake: an issue at t makes `div_busy`=1 from t+1 for 7 cycles. The station issues again only after `div_busy` falls.
  - The divider's `busy` is low out of reset, so the first issue needs no wait.
- `count` and `full` are registered and reflect state after the previous edge.
- Simultaneous dispatch and issue in one cycle: `count` is unchanged.
- Reset asserted mid-operation discards all entries immediately. The divider is reset by the same signal.

## Structure

- Shared package `div_rs_pkg`:
  - `TAG_WIDTH` and `DATA_WIDTH` constants.
  - packed struct `rs_src_t` (`ready`, `tag`, `value`).
  - packed struct `rs_entry_t` (`valid`, `dest_tag`, `src1`, `src2`).
- Sub-module `rs_priority_encoder` (lowest-set-bit index plus found flag), instantiated twice: once for free-slot allocation and once for ready-entry selection.

## Test plan

- **Ready dispatch:** reset, then dispatch tag 5, op1=100, op2=7, both ready, `div_busy`=0 -> next cycle `issue_enable`=1, `issue_op1`=100, `issue_op2`=7, `issue_tag`=5; `count` returns to 0.
- **Wakeup:** dispatch tag 3 with src2 waiting on tag 9; CDB broadcasts tag 9 with data 4 two cycles later -> issue on the following cycle with `issue_op2`=4.
- **Dispatch bypass and double wakeup:**
  - Dispatch with src1 waiting on tag 12 while the CDB broadcasts tag 12 = 0x55 -> entry stores 0x55 as ready.
  - An entry waiting on tag 12 in both sources -> both sources capture the value on one broadcast.
- **Busy gating:** two ready entries with a single divider -> second issue only after `div_busy` falls; selection is lowest index first.
- **Full:** fill 4 entries with none ready -> `full`=1, `count`=4; a fifth dispatch is dropped. Issuing one entry frees a slot; a dispatch in the next cycle succeeds.
- **Flush and reset:**
  - `flush` with 3 valid entries and a ready candidate -> no issue, `count`=0 next cycle.
  - Asynchronous `reset` mid-wait -> all outputs 0 immediately.
